// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// mem_responder_pkg : shared word width, default latency, FSM state encoding
// Rev 1.0
// ============================================================================
package mem_responder_pkg;

  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_ADDR_BITS = 8;
  localparam int MEM_LATENCY   = 2;
  // Wide enough for the largest legal latency (15).
  localparam int CNT_BITS      = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// mem_responder_if : CPU memory-bus request/handshake signals
// Rev 1.0
// ============================================================================
interface mem_responder_if
  import mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE
) ();

  logic                 readM;
  logic                 writeM;
  logic [WORD_SIZE-1:0] address;
  logic                 mem_ready;
  logic                 protocol_err;

  modport master (
    output readM, writeM, address,
    input  mem_ready, protocol_err
  );

  modport slave (
    input  readM, writeM, address,
    output mem_ready, protocol_err
  );

endinterface
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// mem_array : DEPTH x WIDTH storage, synchronous write, combinational read
// Rev 1.0
// ============================================================================
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int WIDTH     = DEF_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS
) (
  input  wire                 clk,
  input  wire                 we,
  input  wire [ADDR_BITS-1:0] addr,
  input  wire [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]    rdata
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : fixed-latency memory responder with one-cycle mem_ready pulse
// Optional access counters enabled by defining MEM_ACCESS_COUNT_EN.  Rev 1.0
// ============================================================================
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int LATENCY   = MEM_LATENCY
) (
  input  wire                  clk,
  input  wire                  reset,
  mem_responder_if.slave       bus,
  inout  wire [WORD_SIZE-1:0]  data
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [WORD_SIZE-1:0] num_reads,
  output logic [WORD_SIZE-1:0] num_writes
`endif
);

  state_t               state;
  state_t               next_state;
  logic [CNT_BITS-1:0]  cnt;
  logic [CNT_BITS-1:0]  cnt_next;
  logic                 op_write;
  logic [ADDR_BITS-1:0] lat_addr;
  logic [WORD_SIZE-1:0] lat_data;
  logic [WORD_SIZE-1:0] rd_word;
  logic                 accept;
  logic                 set_err;
  logic                 ready;
  logic                 mem_we;
  logic                 drive_rd;
  logic                 req_held;
  logic                 protocol_err;

  // Only the request bit of the latched operation keeps an access alive.
  assign req_held = op_write ? bus.writeM : bus.readM;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    set_err    = 1'b0;
    ready      = 1'b0;
    mem_we     = 1'b0;
    drive_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.readM && bus.writeM) begin
          set_err = 1'b1;
        end else if (bus.readM || bus.writeM) begin
          accept     = 1'b1;
          cnt_next   = CNT_BITS'(LATENCY - 1);
          next_state = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          cnt_next   = '0;
          next_state = IDLE;
        end else begin
          cnt_next = cnt - 1'b1;
          if (cnt == CNT_BITS'(1)) begin
            next_state = RESP;
          end
        end
      end
      RESP: begin
        ready      = 1'b1;
        drive_rd   = !op_write;
        mem_we     = op_write;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (set_err) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Request fields are captured once; later bus changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_write <= bus.writeM;
      lat_addr <= bus.address[ADDR_BITS-1:0];
      lat_data <= data;
    end
  end

  mem_array #(
    .WIDTH     (WORD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_mem_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (rd_word)
  );

  assign data             = drive_rd ? rd_word : {WORD_SIZE{1'bz}};
  assign bus.mem_ready    = ready;
  assign bus.protocol_err = protocol_err;

  generate
    if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_BITS];
    end
  endgenerate

`ifdef MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      num_reads  <= '0;
      num_writes <= '0;
    end else if (state == RESP) begin
      if (op_write) begin
        num_writes <= num_writes + 1'b1;
      end else begin
        num_reads <= num_reads + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : three responders (LATENCY 1, 2, 3) against a memory model
// Rev 1.0
// ============================================================================
module tb_mem_responder;

  localparam int W  = 16;
  localparam int NI = 3;
  localparam logic [W-1:0] IDLE_BUS = 16'hFFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd   [NI];
  logic         wr   [NI];
  logic         den  [NI];
  logic [W-1:0] addr [NI];
  logic [W-1:0] wdat [NI];
  logic [W-1:0] dbus [NI];
  logic         rdy  [NI];
  logic         perr [NI];
`ifdef MEM_ACCESS_COUNT_EN
  logic [W-1:0] nrd  [NI];
  logic [W-1:0] nwr  [NI];
`endif

  logic [W-1:0] ref_mem [NI][256];
  logic [7:0]   wlist   [NI][64];
  int           wcnt    [NI];
  int           ref_nrd [NI];
  int           ref_nwr [NI];
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    mem_responder_if #(.WORD_SIZE(W)) bus ();
    wire [W-1:0] d;
    pullup pu (d);
    assign d           = den[i] ? wdat[i] : 'z;
    assign dbus[i]     = d;
    assign bus.readM   = rd[i];
    assign bus.writeM  = wr[i];
    assign bus.address = addr[i];
    assign rdy[i]      = bus.mem_ready;
    assign perr[i]     = bus.protocol_err;

    mem_responder #(.WORD_SIZE(W), .ADDR_BITS(8), .LATENCY(i + 1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .data  (d)
`ifdef MEM_ACCESS_COUNT_EN
      ,
      .num_reads  (nrd[i]),
      .num_writes (nwr[i])
`endif
    );
  end

  // Drives one access on instance k and reports what was observed; the
  // reference memory/counters are updated from the request itself.
  task automatic access(input int k, input bit is_wr, input logic [W-1:0] a,
                        input logic [W-1:0] wd, input bit release_after,
                        output int lat, output logic [W-1:0] rdata, output bit quiet);
    @(negedge clk);
    addr[k] = a; wdat[k] = wd; den[k] = is_wr; rd[k] = !is_wr; wr[k] = is_wr;
    lat = 0; rdata = '0; quiet = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (rdy[k]) begin
        lat = c; rdata = dbus[k];
        break;
      end
      if (!is_wr && dbus[k] !== IDLE_BUS) quiet = 1'b0;
      if (release_after) begin
        addr[k] = W'($urandom);
        if (is_wr) wdat[k] = W'($urandom);
      end
    end
    @(negedge clk);
    if (release_after) begin
      rd[k] = 1'b0; wr[k] = 1'b0; den[k] = 1'b0;
    end
    if (is_wr) begin
      ref_mem[k][a[7:0]] = wd;
      if (wcnt[k] < 64) begin
        wlist[k][wcnt[k]] = a[7:0];
        wcnt[k]++;
      end
      ref_nwr[k]++;
    end else begin
      ref_nrd[k]++;
    end
  endtask

  function automatic logic [W-1:0] pick_written(input int k);
    logic [7:0] lo;
    lo = wlist[k][$urandom_range(0, wcnt[k] - 1)];
    return {8'($urandom), lo};
  endfunction

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] v;
    v = W'($urandom);
    if (v == IDLE_BUS) v = 16'h7FFF;
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++; if (rdy[k] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", k, rdy[k]); end
      checks++; if (perr[k] !== 1'b0) begin errors++; $display("FAIL reset_perr[%0d]: got %b expected 0", k, perr[k]); end
      checks++; if (dbus[k] !== IDLE_BUS) begin errors++; $display("FAIL reset_bus[%0d]: got %h expected released", k, dbus[k]); end
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [W-1:0] rv; bit q;
    access(1, 1'b1, 16'h0010, 16'hBEEF, 1'b1, lat, rv, q);
    checks++; if (lat != 2) begin errors++; $display("FAIL wr_latency: got %0d expected 2", lat); end
    @(posedge clk); #1;
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL wr_pulse_width: got %b expected 0", rdy[1]); end
    access(1, 1'b0, 16'h0010, '0, 1'b1, lat, rv, q);
    checks++; if (lat != 2) begin errors++; $display("FAIL rd_latency: got %0d expected 2", lat); end
    checks++; if (rv !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h expected BEEF", rv); end
    checks++; if (!q) begin errors++; $display("FAIL rd_bus_idle: got driven expected released"); end
    @(posedge clk); #1;
    checks++; if (dbus[1] !== IDLE_BUS) begin errors++; $display("FAIL rd_bus_after: got %h expected released", dbus[1]); end
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] rv, a, wd; bit q, is_wr;
    for (int k = 0; k < NI; k++) begin
      for (int n = 0; n < 12; n++) begin
        is_wr = (wcnt[k] == 0) || ($urandom_range(0, 1) == 1);
        a     = is_wr ? W'($urandom) : pick_written(k);
        wd    = rand_word();
        access(k, is_wr, a, wd, 1'b1, lat, rv, q);
        checks++; if (lat != k + 1) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", k, lat, k + 1); end
        if (!is_wr) begin
          checks++; if (rv !== ref_mem[k][a[7:0]]) begin errors++; $display("FAIL rand_rdata[%0d] @%h: got %h expected %h", k, a, rv, ref_mem[k][a[7:0]]); end
          checks++; if (!q) begin errors++; $display("FAIL rand_bus_idle[%0d]: got driven expected released", k); end
        end
        @(posedge clk); #1;
        checks++; if (rdy[k] !== 1'b0) begin errors++; $display("FAIL rand_pulse[%0d]: got %b expected 0", k, rdy[k]); end
      end
    end
  endtask

  // Request held continuously: pulses every LATENCY+1 cycles.
  task automatic test_back_to_back();
    logic [W-1:0] a1, a2, expd; bit exp_rdy;
    for (int k = 0; k < NI; k++) begin
      a1 = pick_written(k);
      a2 = pick_written(k);
      @(negedge clk);
      addr[k] = a1; rd[k] = 1'b1;
      for (int c = 1; c <= 2 * (k + 1) + 3; c++) begin
        @(posedge clk); #1;
        exp_rdy = (c == k + 1) || (c == 2 * (k + 1) + 1);
        checks++; if (rdy[k] !== exp_rdy) begin errors++; $display("FAIL b2b_ready[%0d] cyc %0d: got %b expected %b", k, c, rdy[k], exp_rdy); end
        expd = !exp_rdy ? IDLE_BUS : (c == k + 1) ? ref_mem[k][a1[7:0]] : ref_mem[k][a2[7:0]];
        checks++; if (dbus[k] !== expd) begin errors++; $display("FAIL b2b_bus[%0d] cyc %0d: got %h expected %h", k, c, dbus[k], expd); end
        if (c == k + 1) addr[k] = a2;
        if (c == 2 * (k + 1) + 1) rd[k] = 1'b0;
      end
      ref_nrd[k] += 2;
    end
  endtask

  task automatic test_abort();
    int lat; logic [W-1:0] rv, a; bit q;
    a = pick_written(2);
    // Read dropped right after acceptance.
    @(negedge clk);
    addr[2] = a; rd[2] = 1'b1;
    @(negedge clk);
    rd[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (rdy[2] !== 1'b0 || dbus[2] !== IDLE_BUS) begin errors++; $display("FAIL abort_read cyc %0d: got ready=%b bus=%h expected 0/released", c, rdy[2], dbus[2]); end
    end
    // Write dropped on the last WAIT edge must not reach memory.
    @(negedge clk);
    addr[2] = a; wr[2] = 1'b1; den[2] = 1'b1; wdat[2] = ~ref_mem[2][a[7:0]];
    repeat (2) @(negedge clk);
    wr[2] = 1'b0; den[2] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++; if (rdy[2] !== 1'b0) begin errors++; $display("FAIL abort_write_ready cyc %0d: got %b expected 0", c, rdy[2]); end
    end
    access(2, 1'b0, a, '0, 1'b1, lat, rv, q);
    checks++; if (lat != 3) begin errors++; $display("FAIL abort_next_latency: got %0d expected 3", lat); end
    checks++; if (rv !== ref_mem[2][a[7:0]]) begin errors++; $display("FAIL abort_next_data: got %h expected %h", rv, ref_mem[2][a[7:0]]); end
  endtask

  task automatic test_protocol_err();
    int lat; logic [W-1:0] rv, a; bit q;
    a = pick_written(1);
    @(negedge clk);
    addr[1] = a; rd[1] = 1'b1; wr[1] = 1'b1; den[1] = 1'b1; wdat[1] = ~ref_mem[1][a[7:0]];
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL perr_ready cyc %0d: got %b expected 0", c, rdy[1]); end
    end
    checks++; if (perr[1] !== 1'b1) begin errors++; $display("FAIL perr_set: got %b expected 1", perr[1]); end
    @(negedge clk);
    rd[1] = 1'b0; wr[1] = 1'b0; den[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (perr[1] !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b expected 1", perr[1]); end
    checks++; if (perr[0] !== 1'b0) begin errors++; $display("FAIL perr_other: got %b expected 0", perr[0]); end
    access(1, 1'b0, a, '0, 1'b1, lat, rv, q);
    checks++; if (rv !== ref_mem[1][a[7:0]]) begin errors++; $display("FAIL perr_mem_unchanged: got %h expected %h", rv, ref_mem[1][a[7:0]]); end
  endtask

  task automatic test_wrap_reset();
    int lat; logic [W-1:0] rv; bit q;
    access(1, 1'b1, 16'h0105, 16'h1234, 1'b1, lat, rv, q);
    access(1, 1'b0, 16'h0005, '0, 1'b1, lat, rv, q);
    checks++; if (rv !== 16'h1234) begin errors++; $display("FAIL wrap_data: got %h expected 1234", rv); end
    @(negedge clk);
    addr[1] = 16'h0005; wr[1] = 1'b1; den[1] = 1'b1; wdat[1] = 16'hFFFF;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy[1] !== 1'b0) begin errors++; $display("FAIL reset_midop_ready: got %b expected 0", rdy[1]); end
    @(negedge clk);
    reset = 1'b0; wr[1] = 1'b0; den[1] = 1'b0;
    for (int k = 0; k < NI; k++) begin ref_nrd[k] = 0; ref_nwr[k] = 0; end
    @(posedge clk); #1;
    checks++; if (perr[1] !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %b expected 0", perr[1]); end
    checks++; if (dbus[1] !== IDLE_BUS) begin errors++; $display("FAIL reset_bus_released: got %h expected released", dbus[1]); end
    access(1, 1'b0, 16'h0005, '0, 1'b1, lat, rv, q);
    checks++; if (rv !== 16'h1234) begin errors++; $display("FAIL reset_discard_write: got %h expected 1234", rv); end
  endtask

  task automatic test_counters();
`ifdef MEM_ACCESS_COUNT_EN
    int lat; logic [W-1:0] rv; bit q;
    for (int k = 0; k < NI; k++) begin
      checks++; if (nrd[k] !== W'(ref_nrd[k])) begin errors++; $display("FAIL num_reads[%0d]: got %0d expected %0d", k, nrd[k], ref_nrd[k]); end
      checks++; if (nwr[k] !== W'(ref_nwr[k])) begin errors++; $display("FAIL num_writes[%0d]: got %0d expected %0d", k, nwr[k], ref_nwr[k]); end
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checks++; if (nrd[k] !== '0 || nwr[k] !== '0) begin errors++; $display("FAIL count_reset[%0d]: got %0d/%0d expected 0/0", k, nrd[k], nwr[k]); end
    end
    for (int n = 0; n < 3; n++) access(2, 1'b1, W'($urandom), rand_word(), 1'b1, lat, rv, q);
    for (int n = 0; n < 2; n++) access(2, 1'b0, pick_written(2), '0, 1'b1, lat, rv, q);
    @(negedge clk); addr[2] = pick_written(2); rd[2] = 1'b1;
    @(negedge clk); rd[2] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (nwr[2] !== 16'd3) begin errors++; $display("FAIL count_writes: got %0d expected 3", nwr[2]); end
    checks++; if (nrd[2] !== 16'd2) begin errors++; $display("FAIL count_reads: got %0d expected 2", nrd[2]); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    for (int k = 0; k < NI; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; den[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
      wcnt[k] = 0; ref_nrd[k] = 0; ref_nwr[k] = 0;
    end
    test_reset();
    test_write_read();
    test_random();
    test_back_to_back();
    test_abort();
    test_protocol_err();
    test_wrap_reset();
    test_counters();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
